xbar_slv_aw_w_arbiter: RTL and testbench

Per-slave-port write arbiter for the AXI crossbar. It shares one slave port's AW and W channels between NUM_MST master ports using round-robin arbitration. It holds the W-channel route to the granted master until that burst's WLAST beat, and prefixes the master index onto AWID so B responses can be routed back. One instance sits in front of each of the AXI_SLAVE_NUMBER_IN_USE slave ports.

---
 rtl/xbar_slv_aw_w_arbiter.sv | 146 ++++++++++++++
 tb/tb_xbar_slv_aw_w_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_slv_aw_w_arbiter.sv
// Round-robin AW/W arbiter in front of one crossbar slave port.
// Holds the W route to the granted master until WLAST; tags AWID with the grant.
module xbar_slv_aw_w_arbiter #(
   parameter  int NUM_MST   = 3,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 64,
   parameter  int ID_W      = 6,
   localparam int MST_IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
   localparam int STRB_W    = DATA_W / 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_MST-1:0]          mst_aw_valid_i,
   output logic [NUM_MST-1:0]          mst_aw_ready_o,
   input  logic [NUM_MST*ID_W-1:0]     mst_aw_id_i,
   input  logic [NUM_MST*ADDR_W-1:0]   mst_aw_addr_i,
   input  logic [NUM_MST*8-1:0]        mst_aw_len_i,
   input  logic [NUM_MST-1:0]          mst_w_valid_i,
   output logic [NUM_MST-1:0]          mst_w_ready_o,
   input  logic [NUM_MST*DATA_W-1:0]   mst_w_data_i,
   input  logic [NUM_MST*STRB_W-1:0]   mst_w_strb_i,
   input  logic [NUM_MST-1:0]          mst_w_last_i,
   output logic                        slv_aw_valid_o,
   input  logic                        slv_aw_ready_i,
   output logic [ID_W+MST_IDX_W-1:0]   slv_aw_id_o,
   output logic [ADDR_W-1:0]           slv_aw_addr_o,
   output logic [7:0]                  slv_aw_len_o,
   output logic                        slv_w_valid_o,
   input  logic                        slv_w_ready_i,
   output logic [DATA_W-1:0]           slv_w_data_o,
   output logic [STRB_W-1:0]           slv_w_strb_o,
   output logic                        slv_w_last_o,
   output logic                        w_len_err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AW   = 2'd1,
      S_W    = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [MST_IDX_W-1:0] r_grant;
   logic [MST_IDX_W-1:0] r_rr_ptr;
   logic [MST_IDX_W-1:0] w_off;
   logic [MST_IDX_W-1:0] w_pick;
   logic [MST_IDX_W-1:0] w_rr_nxt;
   logic [MST_IDX_W:0]   w_sum;
   logic [2*NUM_MST-1:0] w_dbl;
   logic                 w_any_req;
   logic [8:0]           r_cnt;
   logic                 r_err;
   logic [ID_W-1:0]      w_aw_id;
   logic [7:0]           w_aw_len;
   logic                 w_g_wvalid;
   logic                 w_g_wlast;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_bad_len;

   // Rotate requests so bit 0 is the round-robin pointer; lowest set bit wins.
   always_comb begin
      w_dbl     = {mst_aw_valid_i, mst_aw_valid_i} >> r_rr_ptr;
      w_off     = '0;
      w_any_req = |mst_aw_valid_i;
      for (int k = NUM_MST - 1; k >= 0; k--) begin
         if (w_dbl[k]) w_off = MST_IDX_W'(k);
      end
      w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
      if (w_sum >= (MST_IDX_W+1)'(NUM_MST)) begin
         w_sum = w_sum - (MST_IDX_W+1)'(NUM_MST);
      end
      w_pick = w_sum[MST_IDX_W-1:0];
   end

   always_comb begin
      w_aw_id        = '0;
      slv_aw_addr_o  = '0;
      w_aw_len       = '0;
      w_g_wvalid     = 1'b0;
      w_g_wlast      = 1'b0;
      slv_w_data_o   = '0;
      slv_w_strb_o   = '0;
      mst_aw_ready_o = '0;
      mst_w_ready_o  = '0;
      for (int m = 0; m < NUM_MST; m++) begin
         if (r_grant == MST_IDX_W'(m)) begin
            w_aw_id           = mst_aw_id_i[m*ID_W +: ID_W];
            slv_aw_addr_o     = mst_aw_addr_i[m*ADDR_W +: ADDR_W];
            w_aw_len          = mst_aw_len_i[m*8 +: 8];
            w_g_wvalid        = mst_w_valid_i[m];
            w_g_wlast         = mst_w_last_i[m];
            slv_w_data_o      = mst_w_data_i[m*DATA_W +: DATA_W];
            slv_w_strb_o      = mst_w_strb_i[m*STRB_W +: STRB_W];
            mst_aw_ready_o[m] = (r_state == S_AW) && slv_aw_ready_i;
            mst_w_ready_o[m]  = (r_state == S_W) && slv_w_ready_i;
         end
      end
   end

   assign slv_aw_valid_o = (r_state == S_AW);
   assign slv_aw_id_o    = {r_grant, w_aw_id};
   assign slv_aw_len_o   = w_aw_len;
   assign slv_w_valid_o  = (r_state == S_W) && w_g_wvalid;
   assign slv_w_last_o   = w_g_wlast;
   assign w_len_err_o    = r_err;

   assign w_aw_hs   = (r_state == S_AW) && slv_aw_ready_i;
   assign w_w_hs    = (r_state == S_W) && w_g_wvalid && slv_w_ready_i;
   assign w_bad_len = w_g_wlast ? (r_cnt != 9'd1) : (r_cnt <= 9'd1);
   assign w_rr_nxt  = (r_grant == MST_IDX_W'(NUM_MST - 1)) ? '0
                    : r_grant + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_any_req) w_state_nxt = S_AW;
         S_AW:    if (slv_aw_ready_i) w_state_nxt = S_W;
         S_W:     if (w_w_hs && w_g_wlast) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_w_hs && w_bad_len;
         if (r_state == S_IDLE && w_any_req) r_grant <= w_pick;
         // Counter saturates so over-long bursts keep flagging errors.
         if (w_aw_hs) begin
            r_cnt <= {1'b0, w_aw_len} + 9'd1;
         end else if (w_w_hs && r_cnt != 9'd0) begin
            r_cnt <= r_cnt - 9'd1;
         end
         if (w_w_hs && w_g_wlast) r_rr_ptr <= w_rr_nxt;
      end
   end

endmodule

// File: tb/tb_xbar_slv_aw_w_arbiter.sv
// Directed/randomized bench for xbar_slv_aw_w_arbiter.
// Burst-level model: round-robin pick, beat counts, length-error rule.
module tb_xbar_slv_aw_w_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 6;
   localparam int GW = 2;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [N-1:0]      mst_aw_valid_i;
   logic [N-1:0]      mst_aw_ready_o;
   logic [N*IW-1:0]   mst_aw_id_i;
   logic [N*AW-1:0]   mst_aw_addr_i;
   logic [N*8-1:0]    mst_aw_len_i;
   logic [N-1:0]      mst_w_valid_i;
   logic [N-1:0]      mst_w_ready_o;
   logic [N*DW-1:0]   mst_w_data_i;
   logic [N*SW-1:0]   mst_w_strb_i;
   logic [N-1:0]      mst_w_last_i;
   logic              slv_aw_valid_o;
   logic              slv_aw_ready_i;
   logic [IW+GW-1:0]  slv_aw_id_o;
   logic [AW-1:0]     slv_aw_addr_o;
   logic [7:0]        slv_aw_len_o;
   logic              slv_w_valid_o;
   logic              slv_w_ready_i;
   logic [DW-1:0]     slv_w_data_o;
   logic [SW-1:0]     slv_w_strb_o;
   logic              slv_w_last_o;
   logic              w_len_err_o;

   logic [N-1:0]      req;
   logic [IW-1:0]     aw_id   [N];
   logic [AW-1:0]     aw_addr [N];
   logic [7:0]        aw_len  [N];
   logic [N-1:0]      wv;
   logic [DW-1:0]     wd      [N];
   logic [SW-1:0]     ws      [N];
   logic [N-1:0]      wl;

   int   n_vec = 0;
   int   n_err = 0;
   int   rr    = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      mst_aw_valid_i = req;
      mst_aw_id_i    = '0;
      mst_aw_addr_i  = '0;
      mst_aw_len_i   = '0;
      mst_w_valid_i  = wv;
      mst_w_data_i   = '0;
      mst_w_strb_i   = '0;
      mst_w_last_i   = wl;
      for (int m = 0; m < N; m++) begin
         mst_aw_id_i[m*IW +: IW]   = aw_id[m];
         mst_aw_addr_i[m*AW +: AW] = aw_addr[m];
         mst_aw_len_i[m*8 +: 8]    = aw_len[m];
         mst_w_data_i[m*DW +: DW]  = wd[m];
         mst_w_strb_i[m*SW +: SW]  = ws[m];
      end
   end

   xbar_slv_aw_w_arbiter #(
      .NUM_MST (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .ID_W    (IW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .mst_aw_valid_i (mst_aw_valid_i),
      .mst_aw_ready_o (mst_aw_ready_o),
      .mst_aw_id_i    (mst_aw_id_i),
      .mst_aw_addr_i  (mst_aw_addr_i),
      .mst_aw_len_i   (mst_aw_len_i),
      .mst_w_valid_i  (mst_w_valid_i),
      .mst_w_ready_o  (mst_w_ready_o),
      .mst_w_data_i   (mst_w_data_i),
      .mst_w_strb_i   (mst_w_strb_i),
      .mst_w_last_i   (mst_w_last_i),
      .slv_aw_valid_o (slv_aw_valid_o),
      .slv_aw_ready_i (slv_aw_ready_i),
      .slv_aw_id_o    (slv_aw_id_o),
      .slv_aw_addr_o  (slv_aw_addr_o),
      .slv_aw_len_o   (slv_aw_len_o),
      .slv_w_valid_o  (slv_w_valid_o),
      .slv_w_ready_i  (slv_w_ready_i),
      .slv_w_data_o   (slv_w_data_o),
      .slv_w_strb_o   (slv_w_strb_o),
      .slv_w_last_o   (slv_w_last_o),
      .w_len_err_o    (w_len_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input int m, input int len);
      req[m]     = 1'b1;
      aw_id[m]   = IW'($urandom);
      aw_addr[m] = AW'($urandom);
      aw_len[m]  = 8'(len);
   endtask

   task automatic rand_other_w(input int g);
      for (int m = 0; m < N; m++) begin
         if (m != g) begin
            wv[m] = 1'($urandom_range(0, 1));
            wd[m] = {$urandom, $urandom};
            ws[m] = SW'($urandom);
            wl[m] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (req[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   // Beats left before beat i is len+2-i; WLAST must land exactly on 1.
   function automatic logic errexp(input int i, input int len,
                                   input logic last);
      int rem;
      rem = len + 2 - i;
      return last ? (rem != 1) : (rem <= 1);
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_aw_valid"}, slv_aw_valid_o, 0);
      chk({tag, "_aw_ready"}, mst_aw_ready_o, 0);
      chk({tag, "_w_valid"}, slv_w_valid_o, 0);
      chk({tag, "_w_ready"}, mst_w_ready_o, 0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_err", w_len_err_o, 0);
      step();
      rst_i   = 1'b0;
      rr      = 0;
      exp_err = 1'b0;
   endtask

   task automatic serve(input int nb_ovr, input int abort_at,
                        input int aw_stall, input bit bp, input bit rearm);
      int          g, len, nb, i, guard;
      logic        rdy, hs, pres;
      logic [N-1:0] e;
      logic [IW-1:0] idv;
      logic [AW-1:0] adv;
      g = pick();
      if (g < 0) begin
         arm($urandom_range(0, N - 1), $urandom_range(0, 7));
         g = pick();
      end
      len = int'(aw_len[g]);
      idv = aw_id[g];
      adv = aw_addr[g];
      nb  = (nb_ovr > 0) ? nb_ovr : len + 1;
      rand_other_w(-1);
      @(negedge clk);
      chk_quiet("idle");
      chk("idle_err", w_len_err_o, exp_err);
      step();
      for (int s = 0; s <= aw_stall; s++) begin
         slv_aw_ready_i = (s == aw_stall);
         rand_other_w(-1);
         @(negedge clk);
         e = '0;
         if (slv_aw_ready_i) e[g] = 1'b1;
         chk("aw_valid", slv_aw_valid_o, 1);
         chk("aw_id", slv_aw_id_o, {GW'(g), idv});
         chk("aw_addr", slv_aw_addr_o, adv);
         chk("aw_len", slv_aw_len_o, 64'(len));
         chk("aw_ready", mst_aw_ready_o, e);
         chk("aw_w_valid", slv_w_valid_o, 0);
         chk("aw_w_ready", mst_w_ready_o, 0);
         chk("aw_err", w_len_err_o, 0);
         step();
      end
      slv_aw_ready_i = 1'b0;
      if (rearm) arm(g, len);
      else req[g] = 1'b0;
      i       = 1;
      exp_err = 1'b0;
      pres    = 1'b0;
      guard   = 0;
      while (i <= nb) begin
         rand_other_w(g);
         if (!pres) begin
            pres = !bp || ($urandom_range(0, 3) != 0);
            if (pres) begin
               wd[g] = {$urandom, $urandom};
               ws[g] = SW'($urandom);
            end
         end
         rdy = !bp || ($urandom_range(0, 1) == 1);
         if (i == abort_at) begin
            rst_i = 1'b1;
            pres  = 1'b1;
            rdy   = 1'b1;
         end
         wv[g] = pres;
         wl[g] = (i == nb);
         slv_w_ready_i = rdy;
         @(negedge clk);
         e = '0;
         if (rdy) e[g] = 1'b1;
         chk("w_err", w_len_err_o, exp_err);
         chk("w_valid", slv_w_valid_o, wv[g]);
         if (wv[g]) begin
            chk("w_data", slv_w_data_o, wd[g]);
            chk("w_strb", slv_w_strb_o, 64'(ws[g]));
            chk("w_last", slv_w_last_o, 64'(wl[g]));
         end
         chk("w_ready", mst_w_ready_o, e);
         chk("w_aw_valid", slv_aw_valid_o, 0);
         hs      = wv[g] && rdy;
         exp_err = hs && errexp(i, len, wl[g]);
         step();
         if (rst_i) begin
            @(negedge clk);
            chk_quiet("abort");
            chk("abort_err", w_len_err_o, 0);
            step();
            rst_i         = 1'b0;
            rr            = 0;
            exp_err       = 1'b0;
            wv[g]         = 1'b0;
            wl[g]         = 1'b0;
            slv_w_ready_i = 1'b0;
            return;
         end
         if (hs) begin
            i++;
            pres = 1'b0;
         end
         guard++;
         if (guard > 400) begin
            n_vec++;
            n_err++;
            $error("FAIL w_timeout observed=%0d beats expected=%0d", i - 1, nb);
            break;
         end
      end
      wv[g]         = 1'b0;
      wl[g]         = 1'b0;
      slv_w_ready_i = 1'b0;
      rr            = (g + 1) % N;
   endtask

   initial begin
      rst_i          = 1'b1;
      slv_aw_ready_i = 1'b0;
      slv_w_ready_i  = 1'b0;
      req            = '0;
      wv             = '0;
      wl             = '0;
      for (int m = 0; m < N; m++) begin
         aw_id[m]   = '0;
         aw_addr[m] = '0;
         aw_len[m]  = '0;
         wd[m]      = '0;
         ws[m]      = '0;
      end
      do_reset();

      arm(1, 3);
      aw_id[1]   = 6'h2A;
      aw_addr[1] = 32'h1000;
      serve(0, 0, 0, 1'b0, 1'b0);

      do_reset();
      for (int m = 0; m < N; m++) arm(m, 0);
      repeat (6) serve(0, 0, 0, 1'b0, 1'b1);
      req = '0;

      arm(0, $urandom_range(0, 7));
      arm(2, $urandom_range(0, 7));
      repeat (3) serve(0, 0, 5, 1'b1, 1'b0);

      arm(0, 3);
      arm(2, 1);
      serve(0, 0, 1, 1'b0, 1'b0);
      serve(0, 0, 0, 1'b1, 1'b0);

      req = '0;
      arm(0, 3);
      serve(2, 0, 0, 1'b0, 1'b0);
      arm(1, 1);
      serve(4, 0, 0, 1'b1, 1'b0);

      req = '0;
      arm(1, 7);
      serve(0, 2, 0, 1'b0, 1'b0);
      for (int m = 0; m < N; m++) arm(m, $urandom_range(0, 3));
      serve(0, 0, 0, 1'b0, 1'b0);

      repeat (25) begin
         for (int m = 0; m < N; m++) begin
            if ($urandom_range(0, 2) == 0) arm(m, $urandom_range(0, 7));
         end
         serve(($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0,
               0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      req = '0;
      @(negedge clk);
      chk("final_err", w_len_err_o, exp_err);
      chk_quiet("final");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
